// File: rtl/multiaddr_pkg.sv
// rtl/multiaddr_pkg.sv - shared types for the multi-address decoder and expander
package multiaddr_pkg;

  // Expander sequencing: IDLE waits for a request, EXPAND emits its beats.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } expand_state_e;

  localparam int unsigned DefaultAddrWidth = 32;

  // Multi-address request template. A mask bit of 1 marks the matching address
  // bit as "don't care": the request denotes every address that agrees with
  // addr on all bit positions where mask is 0.
  typedef struct packed {
    logic [DefaultAddrWidth-1:0] addr;
    logic [DefaultAddrWidth-1:0] mask;
  } multiaddr_req_t;

endpackage

// File: rtl/multiaddr_expand_popcount.sv
// rtl/multiaddr_expand_popcount.sv - combinational population count cell
module multiaddr_expand_popcount #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  count_o
);

  // Sum of set bits, one adder per input bit.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(Width); i++) begin
      count_o = count_o + CntW'(data_i[i]);
    end
  end

endmodule

// File: rtl/multiaddr_expand.sv
// rtl/multiaddr_expand.sv - serialises an {addr, mask} request into unicast beats
module multiaddr_expand
  import multiaddr_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned MaxSetBits = 8,
  parameter type         addr_t     = logic [AddrWidth-1:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  addr_t in_addr_i,
  input  addr_t in_mask_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  output addr_t out_addr_o,
  output logic  out_last_o,
  output logic  out_err_o,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output logic  busy_o
);

  localparam int unsigned CntW = $clog2(AddrWidth + 1);
  localparam logic [CntW-1:0] MaxSetBitsC = CntW'(MaxSetBits);

  expand_state_e state_q, state_d;
  addr_t         base_q, base_d;
  addr_t         mask_q, mask_d;
  addr_t         cur_q, cur_d;
  logic          err_q, err_d;

  logic [CntW-1:0] in_popcount;
  logic            busy;
  logic            last;
  logic            accept;
  logic            beat_xfer;
  addr_t           cur_next;

  multiaddr_expand_popcount #(
    .Width(AddrWidth),
    .CntW (CntW)
  ) u_popcount (
    .data_i (in_mask_i),
    .count_o(in_popcount)
  );

  // Output decode, handshakes and next-state selection.
  always_comb begin
    busy        = (state_q == EXPAND);
    last        = busy & (err_q | (cur_q == mask_q));
    busy_o      = busy;
    out_valid_o = busy;
    out_addr_o  = busy ? (base_q | cur_q) : '0;
    out_last_o  = last;
    out_err_o   = busy & err_q;

    // A beat shown during a flush is dropped, so it never counts as taken.
    beat_xfer  = busy & out_ready_i & ~flush_i;
    in_ready_o = ~flush_i & (~busy | (beat_xfer & last));
    accept     = in_valid_i & in_ready_o;

    // Next subset of the mask in ascending order: fill the fixed bits with
    // ones so the carry ripples straight through them, then strip them.
    cur_next = ((cur_q | ~mask_q) + addr_t'(1)) & mask_q;

    state_d = state_q;
    base_d  = base_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    err_d   = err_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      if (beat_xfer) begin
        if (last) begin
          state_d = IDLE;
        end else begin
          cur_d = cur_next;
        end
      end
      if (accept) begin
        state_d = EXPAND;
        base_d  = in_addr_i & ~in_mask_i;
        mask_d  = in_mask_i;
        cur_d   = '0;
        err_d   = (in_popcount > MaxSetBitsC);
      end
    end
  end

  // State and request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

endmodule
